// File: rtl/muldiv_unit.sv
// muldiv_unit: multicycle shift-add multiplier and restoring divider sharing one 2*WIDTH datapath
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             N,
  output logic             Z,
  output logic             longOp,
  output logic             divZero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL = 2'b00, OP_SMUL = 2'b01, OP_UMUL = 2'b10, OP_DIV = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             n_q, n_d, z_q, z_d, long_q, long_d, dz_q, dz_d;
  logic             legal, smul_req;
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [2*WIDTH:0] div_sh;
  logic [2*WIDTH-1:0] mul_nx, div_nx, fin;
  logic             by_zero;
  // ALUControl 01xx is the multiply class; low two bits select the op
  assign legal    = ALUControl[3:2] == 2'b01;
  assign smul_req = ALUControl[1:0] == OP_SMUL;
  // multiplier step: add multiplicand into the high half when the multiplier LSB is set, shift right
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign mul_nx   = {mul_sum, p_q[WIDTH-1:1]};
  // divider step: shift remainder:quotient left, trial-subtract divisor, keep on no borrow
  assign div_sh   = {p_q, 1'b0};
  assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, b_q};
  assign div_nx   = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0] : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
  // sign correction for SMUL and the divide-by-zero override both resolve in FIX
  assign fin      = (op_q == OP_SMUL && neg_q) ? -p_q : p_q;
  assign by_zero  = op_q == OP_DIV && b_q == '0;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign N        = n_q;
  assign Z        = z_q;
  assign longOp   = long_q;
  assign divZero  = dz_q;
  // next-state, datapath iteration and result/flag update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    z_d     = z_q;
    long_d  = long_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start && legal) begin
        state_d = CALC;
        op_d    = ALUControl[1:0];
        a_d     = (smul_req && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        b_d     = (smul_req && SrcB[WIDTH-1]) ? -SrcB : SrcB;
        neg_d   = smul_req && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
        p_d     = ALUControl[1:0] == OP_DIV ? {{WIDTH{1'b0}}, SrcA}
                : {{WIDTH{1'b0}}, (smul_req && SrcB[WIDTH-1]) ? -SrcB : SrcB};
        cnt_d   = CW'(WIDTH - 1);
      end
      CALC: begin
        p_d     = op_q == OP_DIV ? div_nx : mul_nx;
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
        state_d = cnt_q == '0 ? FIX : CALC;
      end
      FIX: begin
        state_d = DONE;
        lo_d    = by_zero ? '0 : fin[WIDTH-1:0];
        hi_d    = by_zero ? a_q : fin[2*WIDTH-1:WIDTH];
        long_d  = op_q == OP_UMUL || op_q == OP_SMUL;
        dz_d    = by_zero;
        n_d     = long_d ? hi_d[WIDTH-1] : lo_d[WIDTH-1];
        z_d     = long_d ? {hi_d, lo_d} == '0 : lo_d == '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, async clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      long_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      z_q     <= z_d;
      long_q  <= long_d;
      dz_q    <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, busy, done, n, z, lng, dz;
  logic [3:0]  alu;
  logic [31:0] a, b, lo, hi;
  int          n_chk = 0, n_fail = 0;
  logic        have_prev;
  logic [63:0] prev_r;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(alu), .SrcA(a), .SrcB(b),
    .busy(busy), .done(done), .ResultLo(lo), .ResultHi(hi), .N(n), .Z(z),
    .longOp(lng), .divZero(dz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] r, output logic fn, output logic fz,
                                output logic fl, output logic fd);
    logic [31:0] mx, my;
    mx = x[31] ? -x : x;
    my = y[31] ? -y : y;
    case (op)
      4'b0101: begin
        r = 64'(mx) * 64'(my);
        if (x[31] ^ y[31]) r = -r;
      end
      4'b0111: r = y == 0 ? {x, 32'h0} : {x % y, x / y};
      default: r = 64'(x) * 64'(y);
    endcase
    fl = op == 4'b0110 || op == 4'b0101;
    fd = op == 4'b0111 && y == 0;
    fn = fl ? r[63] : r[31];
    fz = fl ? r == 0 : r[31:0] == 0;
  endfunction
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int pulse_at);
    int lat;
    logic [63:0] r;
    logic fn, fz, fl, fd;
    model(op, x, y, r, fn, fz, fl, fd);
    @(negedge clk);
    if (have_prev) begin
      chk({tag, " prev_held"}, {hi, lo}, prev_r);
      chk({tag, " done_idle"}, done, 0);
    end
    alu = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; alu = 4'($urandom);
    lat = 1;
    while (!done && lat < 60) begin
      start = lat == pulse_at;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, 34);
    chk({tag, " busy"}, busy, 1);
    chk({tag, " result"}, {hi, lo}, r);
    chk({tag, " flags"}, {n, z, lng, dz}, {fn, fz, fl, fd});
    prev_r = r;
    have_prev = 1'b1;
  endtask
  initial begin
    int seen;
    logic [31:0] x, y;
    reset = 1'b1; start = 1'b0; alu = '0; a = '0; b = '0; have_prev = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_status", {busy, done}, 0);
    chk("reset_result", {hi, lo}, 0);
    chk("reset_flags", {n, z, lng, dz}, 0);
    reset = 1'b0;
    run_op("mul7x6", 4'b0100, 7, 6, 0);
    run_op("umul_max", 4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("smul_m3x5", 4'b0101, 32'hFFFFFFFD, 5, 0);
    run_op("smul_0xm7", 4'b0101, 0, 32'hFFFFFFF9, 0);
    run_op("smul_minmin", 4'b0101, 32'h80000000, 32'h80000000, 0);
    run_op("mul_hi", 4'b0100, 32'hDEADBEEF, 32'h12345678, 0);
    run_op("div100_7", 4'b0111, 100, 7, 0);
    run_op("div_by0", 4'b0111, 32'h1234, 0, 0);
    run_op("mid_start", 4'b0100, 32'h0001_0003, 32'h0000_0101, 10);
    @(negedge clk);
    alu = 4'b0011; a = 5; b = 5; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) seen++;
    end
    chk("illegal_ignored", seen, 0);
    chk("illegal_held", {hi, lo}, prev_r);
    @(negedge clk);
    alu = 4'b0110; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_status", {busy, done}, 0);
    chk("abort_result", {hi, lo}, 0);
    chk("abort_flags", {n, z, lng, dz}, 0);
    @(negedge clk);
    reset = 1'b0;
    prev_r = '0;
    run_op("after_abort", 4'b0111, 32'hFFFFFFFF, 3, 0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin x = $urandom_range(0, 300); y = $urandom_range(0, 20); end
        1: begin x = $urandom; y = 0; end
        2: begin x = 32'h80000000 | $urandom; y = $urandom; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      run_op($sformatf("rnd%0d", i), 4'(4 + $urandom_range(0, 3)), x, y, $urandom_range(0, 40));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
